// File: rtl/piano_pkg.sv
// piano_pkg -- shared definitions for the electronic-piano datapath.
//   MODE_FREE / MODE_AUTO / MODE_LEARN : one-hot mode codes from the switches
//   NOTE_REST                          : note code meaning "no sound"
//   mode_state_t                       : mode_mux_ctrl FSM states
package piano_pkg;

    localparam logic [2:0] MODE_FREE  = 3'b100;
    localparam logic [2:0] MODE_AUTO  = 3'b010;
    localparam logic [2:0] MODE_LEARN = 3'b001;

    localparam int NOTE_REST = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUTE = 2'd1,
        RUN  = 2'd2
    } mode_state_t;

endpackage

// File: rtl/mode_debounce.sv
// mode_debounce -- stability filter for the registered mode request.
// Only built when MODE_DEBOUNCE_EN is defined.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   d          : registered mode request (W bits)
//   q          : accepted mode; takes d once d has held the same value for
//                DEB_CYCLES consecutive cycles, all-zero after reset
`ifdef MODE_DEBOUNCE_EN
module mode_debounce #(
    parameter int W          = 3,
    parameter int DEB_CYCLES = 65536
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [W-1:0]     last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // cnt_nxt = number of consecutive cycles d has held its current value,
    // counting this one; a change counts as cycle 1 of the new window, so
    // the value is accepted exactly DEB_CYCLES cycles after it first appears.
    always_comb begin
        cnt_nxt = cnt;
        if (d != last)
            cnt_nxt = CNT_W'(1);
        else if (cnt != CNT_W'(DEB_CYCLES))
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= '0;
            cnt  <= '0;
            q    <= '0;
        end else begin
            last <= d;
            cnt  <= cnt_nxt;
            if (cnt_nxt == CNT_W'(DEB_CYCLES))
                q <= d;
        end
    end

endmodule
`endif

// File: rtl/mode_mux_ctrl.sv
// mode_mux_ctrl -- selects one playback engine by one-hot mode and drives the
// shared note/LED/octave/display outputs through a registered mux. Each mode
// change inserts a muted gap of MUTE_CYCLES and a one-cycle restart pulse to
// the newly selected engine.
// Optional feature: define MODE_DEBOUNCE_EN to filter the mode request
// through mode_debounce (DEB_CYCLES stability window).
// Ports:
//   clk, reset       : system clock, synchronous active-high reset
//   mode             : one-hot mode request
//   src_note/led/oct/num : flattened per-engine outputs, source i at [i*W +: W]
//   note_out, led_out, octave_out, num : selected engine data (0 outside RUN)
//   mode_active      : one-hot source driving outputs, 0 outside RUN
//   src_restart      : one-cycle restart pulse to the engine being switched to
//   switching        : high during the muted gap
module mode_mux_ctrl
    import piano_pkg::*;
#(
    parameter int NUM_MODES   = 3,
    parameter int NOTE_W      = 4,
    parameter int LED_W       = 7,
    parameter int OCT_W       = 2,
    parameter int NUM_W       = 4,
    parameter int MUTE_CYCLES = 4,
    parameter int DEB_CYCLES  = 65536
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_MODES-1:0]        mode,
    input  logic [NUM_MODES*NOTE_W-1:0] src_note,
    input  logic [NUM_MODES*LED_W-1:0]  src_led,
    input  logic [NUM_MODES*OCT_W-1:0]  src_oct,
    input  logic [NUM_MODES*NUM_W-1:0]  src_num,
    output logic [NOTE_W-1:0]           note_out,
    output logic [LED_W-1:0]            led_out,
    output logic [OCT_W-1:0]            octave_out,
    output logic [NUM_W-1:0]            num,
    output logic [NUM_MODES-1:0]        mode_active,
    output logic [NUM_MODES-1:0]        src_restart,
    output logic                        switching
);

    localparam int IDX_W = $clog2(NUM_MODES);
    localparam int CNT_W = $clog2(MUTE_CYCLES + 1);

    logic [NUM_MODES-1:0] mode_q;
    logic [NUM_MODES-1:0] acc;
    logic                 acc_valid;
    logic                 acc_zero;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     sel;
    logic [CNT_W-1:0]     cnt;
    mode_state_t          state;

    logic [NOTE_W-1:0]    sel_note;
    logic [LED_W-1:0]     sel_led;
    logic [OCT_W-1:0]     sel_oct;
    logic [NUM_W-1:0]     sel_num;

    always_ff @(posedge clk) begin
        if (reset) mode_q <= '0;
        else       mode_q <= mode;
    end

`ifdef MODE_DEBOUNCE_EN
    mode_debounce #(
        .W          (NUM_MODES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .d     (mode_q),
        .q     (acc)
    );
`else
    assign acc = mode_q;
`endif

    assign acc_valid = $onehot(acc);
    assign acc_zero  = (acc == '0);

    // Index of the set bit; only meaningful when acc_valid.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_MODES; i++)
            if (acc[i]) cand = cand | IDX_W'(i);
    end

    assign sel_note = src_note[sel*NOTE_W +: NOTE_W];
    assign sel_led  = src_led [sel*LED_W  +: LED_W];
    assign sel_oct  = src_oct [sel*OCT_W  +: OCT_W];
    assign sel_num  = src_num [sel*NUM_W  +: NUM_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            cnt         <= '0;
            note_out    <= '0;
            led_out     <= '0;
            octave_out  <= '0;
            num         <= '0;
            mode_active <= '0;
            src_restart <= '0;
            switching   <= 1'b0;
        end else begin
            src_restart <= '0;
            if (acc_zero) begin
                state       <= IDLE;
                note_out    <= '0;
                led_out     <= '0;
                octave_out  <= '0;
                num         <= '0;
                mode_active <= '0;
                switching   <= 1'b0;
            end else if (acc_valid && (state == IDLE || cand != sel)) begin
                // New engine: (re)start the muted gap, also when already muting.
                state       <= MUTE;
                sel         <= cand;
                cnt         <= CNT_W'(MUTE_CYCLES);
                src_restart <= NUM_MODES'(1) << cand;
                note_out    <= '0;
                led_out     <= '0;
                octave_out  <= '0;
                num         <= '0;
                mode_active <= '0;
                switching   <= 1'b1;
            end else if (acc_valid) begin
                case (state)
                    MUTE: begin
                        if (cnt == CNT_W'(1)) begin
                            state       <= RUN;
                            switching   <= 1'b0;
                            note_out    <= sel_note;
                            led_out     <= sel_led;
                            octave_out  <= sel_oct;
                            num         <= sel_num;
                            mode_active <= NUM_MODES'(1) << sel;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    RUN: begin
                        note_out    <= sel_note;
                        led_out     <= sel_led;
                        octave_out  <= sel_oct;
                        num         <= sel_num;
                        mode_active <= NUM_MODES'(1) << sel;
                    end
                    default: state <= IDLE;
                endcase
            end
            // Multi-bit requests fall through: everything holds.
        end
    end

endmodule

// File: doc/mode_mux_ctrl.md
# mode_mux_ctrl

Parametrised mode controller for the electronic-piano datapath. It selects one of `NUM_MODES` playback engines (free, auto, learn, and future engines) by a one-hot mode input and drives the shared note/LED/octave/display outputs from the selected engine through a registered mux. Every mode change inserts a muted switch-over gap and sends a one-cycle restart pulse to the newly selected engine, so the buzzer and LEDs never glitch between sources. It sits between the per-mode engines and the audio/LED/seven-segment drivers.

## Interface
- `NUM_MODES`, 3: number of engine sources; mode bit i selects source i. Minimum 2.
- `NOTE_W`, 4: note code width; code 0 means rest.
- `LED_W`, 7: LED vector width.
- `OCT_W`, 2: octave width.
- `NUM_W`, 4: display digit width.
- `MUTE_CYCLES`, 4: switch-over gap length in cycles. Minimum 1.
- `DEB_CYCLES`, 65536: mode-input stability window; used only with `MODE_DEBOUNCE_EN`.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  NUM_MODES  one-hot mode request from the switches.
- `src_note`  in  NUM_MODES*NOTE_W  flattened engine notes; source i at bits [i*NOTE_W +: NOTE_W].
- `src_led`  in  NUM_MODES*LED_W  flattened engine LED vectors.
- `src_oct`  in  NUM_MODES*OCT_W  flattened engine octaves.
- `src_num`  in  NUM_MODES*NUM_W  flattened engine display digits.
- `note_out`  out  NOTE_W  selected note; reset 0.
- `led_out`  out  LED_W  selected LEDs; reset 0.
- `octave_out`  out  OCT_W  selected octave; reset 0.
- `num`  out  NUM_W  selected display digit; reset 0.
- `mode_active`  out  NUM_MODES  one-hot source currently driving outputs; all-zero outside RUN; reset 0.
- `src_restart`  out  NUM_MODES  one-cycle restart pulse to the engine being switched to; reset 0.
- `switching`  out  1  high while in MUTE; reset 0.

## Operation
- `mode` is always registered once into `mode_q`. The accepted mode is `mode_q`; with debounce enabled, it is the debounced value.
- FSM states: IDLE, MUTE, RUN. Reset enters IDLE, clears all outputs, and clears the stored index `sel`.
- Accepted mode is valid when exactly one bit is set; `cand` is its index.
- IDLE: on a valid accepted mode, load `sel` from `cand`, load the counter with `MUTE_CYCLES`, pulse `src_restart[cand]`, and go to MUTE.
- MUTE: all four data outputs are 0 and `switching` is 1. The counter decrements each cycle. At count 1, go to RUN.
- RUN: each cycle, outputs load source `sel`, and `mode_active` is one-hot `sel`. Any new value on the source inputs appears on the outputs one cycle later.
- Mode change from MUTE or RUN to a valid mode with `cand != sel`: go to MUTE, reload the counter, update `sel`, and pulse `src_restart[cand]`. A change arriving during MUTE restarts the gap.
- Accepted value equal to the current `sel`: no action.
- Accepted value all-zero, from any state: go to IDLE next cycle, outputs 0, `mode_active` 0.
- Accepted value with 2 or more bits set: ignored; the state, `sel` and outputs are held.
- Reset mid-MUTE or mid-RUN: IDLE next cycle, all outputs 0, no `src_restart` pulse.

## Timing
- `mode` changes before edge t. `mode_q` updates at edge t. At edge t+1: `src_restart` is high for that cycle only, `switching` is 1, and data outputs are 0.
- MUTE lasts exactly `MUTE_CYCLES` cycles. Source data is loaded at edge t+1+`MUTE_CYCLES`, which is also the cycle `switching` drops.
- Output latency in RUN: 1 cycle from source input to output.
- Debounce adds exactly `DEB_CYCLES` cycles before a new value is accepted.

## Configuration
- `MODE_DEBOUNCE_EN` defined: `mode_q` must hold the same value for `DEB_CYCLES` consecutive cycles before it becomes the accepted mode. Any change restarts the window. After reset, the accepted value is all-zero until the first window completes.
- `MODE_DEBOUNCE_EN` undefined: the accepted mode is `mode_q` directly. `DEB_CYCLES` is unused and no counter is built.

## Structure
- Shared package `piano_pkg` holds:
  - mode one-hot constants `MODE_FREE`=3'b100, `MODE_AUTO`=3'b010, `MODE_LEARN`=3'b001;
  - `NOTE_REST`=0;
  - the FSM state enum `mode_state_t` {IDLE, MUTE, RUN}.
- Sub-module `mode_debounce` (stability counter plus accepted-value register) is instantiated only under `MODE_DEBOUNCE_EN`.

## Test plan
All scenarios use NUM_MODES=3, MUTE_CYCLES=4, and no debounce unless stated.
- Reset, then `mode`=3'b010 with source 1 note=5 → `src_restart`=3'b010 for one cycle. `switching`=1 for 4 cycles with `note_out`=0. Then `note_out`=5 and `mode_active`=3'b010.
- In RUN on source 1, change `mode` to 3'b001 with source 0 note=9, led=7'h7F → 4-cycle mute. Then `note_out`=9, `led_out`=7'h7F, and `src_restart` pulses on bit 0 only.
- Switch to 3'b100, then to 3'b001 two cycles later → the gap restarts, and outputs come from source 0 exactly 4 cycles after the second change.
- `mode`=3'b110 while in RUN → outputs and `mode_active` unchanged, no pulse. Then `mode`=3'b000 → IDLE, all outputs 0.
- Assert `reset` during cycle 2 of MUTE → all outputs 0 and `switching`=0 the next cycle. With `mode` still valid after release, a fresh switch-over runs.
- With `MODE_DEBOUNCE_EN` and DEB_CYCLES=8, toggle `mode` every 5 cycles → never accepted. Hold it stable for 8 cycles → switch-over begins.
